// File: rtl/song_tutor_pkg.sv
// song_tutor_pkg: note codes, LED patterns, note-to-LED map and FSM state encoding.
package song_tutor_pkg;
   localparam logic [3:0] NOTE_NONE = 4'd0;
   localparam logic [3:0] NOTE_C4   = 4'd1;
   localparam logic [3:0] NOTE_D    = 4'd2;
   localparam logic [3:0] NOTE_E    = 4'd3;
   localparam logic [3:0] NOTE_F    = 4'd4;
   localparam logic [3:0] NOTE_G    = 4'd5;
   localparam logic [3:0] NOTE_A    = 4'd6;
   localparam logic [3:0] NOTE_B    = 4'd7;
   localparam logic [3:0] NOTE_C5   = 4'd8;

   localparam logic [7:0] LED_OFF = 8'h00;
   localparam logic [7:0] LED_C4  = 8'h01;
   localparam logic [7:0] LED_D   = 8'h02;
   localparam logic [7:0] LED_E   = 8'h04;
   localparam logic [7:0] LED_F   = 8'h08;
   localparam logic [7:0] LED_G   = 8'h10;
   localparam logic [7:0] LED_A   = 8'h20;
   localparam logic [7:0] LED_B   = 8'h40;
   localparam logic [7:0] LED_C5  = 8'h80;
   localparam logic [7:0] LED_ALL = 8'hFF;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_WAIT_PRESS,
      ST_WAIT_RELEASE,
      ST_WAIT_WRONG_RELEASE,
      ST_DONE
   } state_e;

   function automatic logic [7:0] note_led(input logic [3:0] n);
      case (n)
         NOTE_C4: return LED_C4;
         NOTE_D:  return LED_D;
         NOTE_E:  return LED_E;
         NOTE_F:  return LED_F;
         NOTE_G:  return LED_G;
         NOTE_A:  return LED_A;
         NOTE_B:  return LED_B;
         NOTE_C5: return LED_C5;
         default: return LED_OFF;
      endcase
   endfunction
endpackage

// File: rtl/song_tutor_mem.sv
// song_mem: song note storage, synchronous write and asynchronous read; not touched by reset.
module song_mem
   import song_tutor_pkg::*;
#(
   parameter int NOTE_W  = 4,
   parameter int MAX_LEN = 64,
   parameter int ADDR_W  = $clog2(MAX_LEN)
) (
   input  logic              clk_i,
   input  logic              wr_en_i,
   input  logic [ADDR_W-1:0] wr_addr_i,
   input  logic [NOTE_W-1:0] wr_note_i,
   input  logic [ADDR_W-1:0] rd_addr_i,
   output logic [NOTE_W-1:0] rd_note_o
);
   logic [NOTE_W-1:0] mem_q [MAX_LEN];

   // Addresses past the array (non power-of-two depth) are dropped on write and read as none
   always_ff @(posedge clk_i)
      if (wr_en_i && 32'(wr_addr_i) < MAX_LEN) mem_q[wr_addr_i] <= wr_note_i;

   assign rd_note_o = (32'(rd_addr_i) < MAX_LEN) ? mem_q[rd_addr_i] : NOTE_W'(NOTE_NONE);
endmodule

// File: rtl/song_tutor.sv
// song_tutor: guides a player through a stored song, tracking position, mistakes and idle hints.
module song_tutor
   import song_tutor_pkg::*;
#(
   parameter int NOTE_W  = 4,
   parameter int MAX_LEN = 64,
   parameter int TIMEOUT = 50_000_000,
   parameter int ERR_W   = 8,
   parameter int ADDR_W  = $clog2(MAX_LEN)
) (
   input  logic              CLK,
   input  logic              RESET_N,
   input  logic              START,
   input  logic              STRICT,
   input  logic [NOTE_W-1:0] note,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [NOTE_W-1:0] wr_note,
   input  logic [ADDR_W:0]   song_len,
   output logic [7:0]        Led,
   output logic [ADDR_W-1:0] pos,
   output logic [ERR_W-1:0]  err_count,
   output logic              hint,
   output logic              done
);
   localparam int CNT_W = $clog2(TIMEOUT + 2);

   state_e            state_q;
   logic [ADDR_W-1:0] pos_q;
   logic [ADDR_W:0]   len_q;
   logic [ERR_W-1:0]  err_q;
   logic [CNT_W-1:0]  idle_q;
   logic              done_q;
   logic [7:0]        led_q;
   logic [NOTE_W-1:0] rd_note;
   logic              last;

   song_mem #(.NOTE_W(NOTE_W), .MAX_LEN(MAX_LEN), .ADDR_W(ADDR_W)) u_mem (
      .clk_i    (CLK),
      .wr_en_i  (wr_en),
      .wr_addr_i(wr_addr),
      .wr_note_i(wr_note),
      .rd_addr_i(pos_q),
      .rd_note_o(rd_note)
   );

   assign last = {1'b0, pos_q} == len_q - 1'b1;

   always_ff @(posedge CLK or negedge RESET_N)
      if (!RESET_N) begin
         state_q <= ST_IDLE;
         pos_q   <= '0;
         len_q   <= '0;
         err_q   <= '0;
         idle_q  <= '0;
         done_q  <= 1'b0;
         led_q   <= LED_OFF;
      end else begin
         // LED follows the registered state/position with one cycle of latency
         led_q  <= state_q == ST_IDLE ? LED_OFF : state_q == ST_DONE ? LED_ALL : note_led(4'(rd_note));
         idle_q <= '0;
         if (START) begin
            len_q   <= song_len;
            pos_q   <= '0;
            err_q   <= '0;
            done_q  <= song_len == '0;
            state_q <= song_len == '0 ? ST_DONE : ST_WAIT_PRESS;
         end else begin
            case (state_q)
               ST_WAIT_PRESS:
                  if (note == '0) begin
                     idle_q <= idle_q == CNT_W'(TIMEOUT) ? idle_q : idle_q + 1'b1;
                  end else if (note == rd_note) begin
                     state_q <= ST_WAIT_RELEASE;
                  end else begin
                     state_q <= ST_WAIT_WRONG_RELEASE;
                     err_q   <= &err_q ? err_q : err_q + 1'b1;
                     pos_q   <= STRICT ? '0 : pos_q;
                  end
               ST_WAIT_RELEASE:
                  if (note == '0) begin
                     state_q <= last ? ST_DONE : ST_WAIT_PRESS;
                     done_q  <= last;
                     pos_q   <= last ? pos_q : pos_q + 1'b1;
                  end
               ST_WAIT_WRONG_RELEASE:
                  if (note == '0) state_q <= ST_WAIT_PRESS;
               default: ;
            endcase
         end
      end

   assign Led       = led_q;
   assign pos       = pos_q;
   assign err_count = err_q;
   assign done      = done_q;
   assign hint      = state_q == ST_WAIT_PRESS && idle_q >= CNT_W'(TIMEOUT);
endmodule

// File: doc/song_tutor.md
SONG_TUTOR -- requirements
Module: song_tutor

Interface
REQ-001 Parameter NOTE_W, default 4: width of a note code; code 0 means no key pressed ("none").
REQ-002 Parameter MAX_LEN, default 64: song memory depth; ADDR_W = clog2(MAX_LEN).
REQ-003 Parameter TIMEOUT, default 50_000_000: idle cycles in WAIT_PRESS before hint asserts.
REQ-004 Parameter ERR_W, default 8: width of the error counter.
REQ-005 Ports: CLK in 1, the single clock; RESET_N in 1, reset (one clock; reset is asynchronous and active-low).
REQ-006 START in 1, synchronous restart of a lesson at position 0.
REQ-007 STRICT in 1, mode: 1 = wrong note returns to position 0, 0 = wrong note holds position.
REQ-008 note in NOTE_W, debounced key currently held (0 = none).
REQ-009 wr_en in 1, wr_addr in ADDR_W, wr_note in NOTE_W: song memory write port.
REQ-010 song_len in ADDR_W+1, number of notes in the song; sampled on START.
REQ-011 Led out 8, LED pattern of the expected note.
REQ-012 pos out ADDR_W, index of the expected note; err_count out ERR_W; hint out 1; done out 1.

Function
REQ-013 States: IDLE, WAIT_PRESS, WAIT_RELEASE, WAIT_WRONG_RELEASE, DONE.
REQ-014 IDLE: outputs hold reset values; START -> WAIT_PRESS with pos=0, err_count=0, len latched.
REQ-015 START in any state SHALL behave as in IDLE and take priority over all other transitions.
REQ-016 START with latched len 0 SHALL go directly to DONE.
REQ-017 WAIT_PRESS: note==0 stays; note==mem[pos] -> WAIT_RELEASE; other nonzero note -> WAIT_WRONG_RELEASE.
REQ-018 On wrong note, err_count SHALL increment by 1, saturating at all-ones.
REQ-019 On wrong note, pos SHALL go to 0 if STRICT=1, otherwise SHALL stay unchanged; STRICT is sampled on the same cycle.
REQ-020 WAIT_WRONG_RELEASE: stays until note==0, then -> WAIT_PRESS.
REQ-021 WAIT_RELEASE: stays until note==0; then, if pos==len-1, go to DONE, else pos+1 and go to WAIT_PRESS.
REQ-022 A press changing directly to another nonzero note SHALL be ignored until release (no new match).
REQ-023 DONE: done=1, pos holds last index; remains until START.
REQ-024 Led SHALL be registered: one cycle after pos/state change it shows map(mem[pos]); in IDLE it is 8'h00; in DONE it is 8'hFF.
REQ-025 Idle counter SHALL count cycles in WAIT_PRESS with note==0, clear on any state change or START; hint=1 while count>=TIMEOUT; the counter saturates.
REQ-026 Memory write SHALL take effect the cycle after wr_en; a write to the address being compared is visible on the next comparison.
REQ-027 Writes with wr_addr>=MAX_LEN SHALL be ignored.

Reset
REQ-028 RESET_N low SHALL asynchronously force IDLE, pos=0, err_count=0, hint=0, done=0, Led=8'h00, idle counter=0.
REQ-029 Song memory contents SHALL NOT be cleared by reset.
REQ-030 Reset release mid-lesson SHALL require a new START.

Structure
REQ-031 Shared package: note code constants (none, C4, D, E, F, G, A, B, C5), LED pattern constants, note-to-LED map function, state encoding.
REQ-032 One sub-module song_mem: MAX_LEN x NOTE_W register array, synchronous write, asynchronous read.

Verification
REQ-033 Load E,E,F,G (len 4), START, play each with release -> pos 0..3, Led=map(E),map(E),map(F),map(G), done=1, err_count=0.
REQ-034 STRICT=1, at pos 2 press D then release -> err_count=1, pos=0, state WAIT_PRESS.
REQ-035 STRICT=0, at pos 2 press D, release, press F -> err_count=1, pos stays 2 then advances to 3.
REQ-036 TIMEOUT=10, idle in WAIT_PRESS 10 cycles -> hint=1 on cycle 10; press correct note -> hint=0 next cycle.
REQ-037 Assert RESET_N low mid-lesson at pos 3 -> same-cycle IDLE, Led=0, err_count=0; memory still holds song.
REQ-038 ERR_W=2, four wrong presses -> err_count saturates at 3; START with len 0 -> done=1 immediately.
